// File: rtl/decode_operand_stage_pkg.sv
// Shared definitions for the decode/operand stage: opcodes, forward selects,
// the ID/EX bundle layout and the per-opcode control decode.
package decode_operand_stage_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  // Where an operand value is taken from.
  typedef enum logic [1:0] {
    FWD_RF   = 2'd0,
    FWD_EX   = 2'd1,
    FWD_MEM  = 2'd2,
    FWD_ZERO = 2'd3
  } fwd_sel_e;

  // Registered ID/EX bundle.
  typedef struct packed {
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc;
    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic [REG_W-1:0]  dest;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              valid;
  } idex_t;

  // A bubble carries no instruction and no side effects; data fields are zeroed.
  localparam idex_t IDEX_BUBBLE = '0;

  // Control fields derived from the opcode alone.
  typedef struct packed {
    logic [REG_W-1:0] dest;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic             uses_rt;
  } ctrl_t;

  // Unknown opcodes decode to "no destination, no writes" but still travel as valid.
  function automatic ctrl_t decode_ctrl(input logic [DATA_W-1:0] instr);
    ctrl_t c;
    c = '0;
    unique case (instr[31:26])
      OP_RTYPE: begin
        c.dest      = instr[15:11];
        c.reg_write = 1'b1;
        c.uses_rt   = 1'b1;
      end
      OP_LW: begin
        c.dest      = instr[20:16];
        c.reg_write = 1'b1;
        c.mem_read  = 1'b1;
      end
      OP_ADDI: begin
        c.dest      = instr[20:16];
        c.reg_write = 1'b1;
      end
      OP_SW: begin
        c.mem_write = 1'b1;
        c.uses_rt   = 1'b1;
      end
      OP_BEQ: begin
        c.uses_rt   = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/decode_operand_stage_hazard_forward_unit.sv
// Combinational forwarding-select and load-use stall logic for the ID stage.
module hazard_forward_unit
  import decode_operand_stage_pkg::*;
(
  input  logic [REG_W-1:0] rs_idx,
  input  logic [REG_W-1:0] rt_idx,
  input  logic             rs_used,
  input  logic             rt_used,
  input  logic             id_valid,
  input  logic             flush,
  input  logic             ex_valid,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_dest,
  input  logic             mem_reg_write,
  input  logic [REG_W-1:0] mem_dest,
  output fwd_sel_e         rs_sel,
  output fwd_sel_e         rt_sel,
  output logic             load_use,
  output logic             stall
);

  // EX wins over MEM; a load in EX cannot forward because its data is not ready yet.
  function automatic fwd_sel_e pick_src(input logic [REG_W-1:0] src,
                                        input logic             ex_fwd_ok,
                                        input logic [REG_W-1:0] ex_d,
                                        input logic             mem_wr,
                                        input logic [REG_W-1:0] mem_d);
    fwd_sel_e sel;
    if (src == '0)                      sel = FWD_ZERO;
    else if (ex_fwd_ok && ex_d == src)  sel = FWD_EX;
    else if (mem_wr && mem_d == src)    sel = FWD_MEM;
    else                                sel = FWD_RF;
    return sel;
  endfunction

  logic ex_fwd_ok;
  logic rs_hit;
  logic rt_hit;

  // Forward selects per operand, and a one-cycle stall when a used source waits on a load in EX.
  always_comb begin
    ex_fwd_ok = ex_valid & ex_reg_write & ~ex_mem_read;
    rs_sel    = pick_src(rs_idx, ex_fwd_ok, ex_dest, mem_reg_write, mem_dest);
    rt_sel    = pick_src(rt_idx, ex_fwd_ok, ex_dest, mem_reg_write, mem_dest);
    rs_hit    = rs_used & (ex_dest == rs_idx);
    rt_hit    = rt_used & (ex_dest == rt_idx);
    load_use  = id_valid & ex_valid & ex_mem_read & (ex_dest != '0) & (rs_hit | rt_hit);
    // A taken branch kills the ID instruction, so there is nothing left to hold.
    stall     = load_use & ~flush;
  end

endmodule

// File: rtl/decode_operand_stage.sv
// ID stage: decode, forwarded operand selection and the ID/EX pipeline register.
module decode_operand_stage
  import decode_operand_stage_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] Instr_ID,
  input  logic [DATA_W-1:0] PC_ID,
  input  logic              Valid_ID,
  input  logic              Flush,
  output logic [REG_W-1:0]  ReadReg1,
  output logic [REG_W-1:0]  ReadReg2,
  input  logic [DATA_W-1:0] ReadData1,
  input  logic [DATA_W-1:0] ReadData2,
  input  logic [DATA_W-1:0] ExResult,
  input  logic [REG_W-1:0]  MemDest,
  input  logic              MemRegWrite,
  input  logic [DATA_W-1:0] MemResult,
  output logic              Stall,
  output logic [DATA_W-1:0] RsVal_EX,
  output logic [DATA_W-1:0] RtVal_EX,
  output logic [DATA_W-1:0] Imm_EX,
  output logic [DATA_W-1:0] PC_EX,
  output logic [5:0]        Opcode_EX,
  output logic [5:0]        Funct_EX,
  output logic [REG_W-1:0]  DestReg_EX,
  output logic              RegWrite_EX,
  output logic              MemRead_EX,
  output logic              MemWrite_EX,
  output logic              Valid_EX
);

  idex_t    idex_q;
  idex_t    idex_d;
  ctrl_t    ctrl;
  fwd_sel_e rs_sel;
  fwd_sel_e rt_sel;
  logic     load_use;
  logic     hz_stall;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;
  logic signed [DATA_W-1:0] imm_sext;

  function automatic logic [DATA_W-1:0] operand_mux(input fwd_sel_e          sel,
                                                    input logic [DATA_W-1:0] rf_val,
                                                    input logic [DATA_W-1:0] ex_val,
                                                    input logic [DATA_W-1:0] mem_val);
    logic [DATA_W-1:0] v;
    unique case (sel)
      FWD_ZERO: v = '0;
      FWD_EX:   v = ex_val;
      FWD_MEM:  v = mem_val;
      default:  v = rf_val;
    endcase
    return v;
  endfunction

  hazard_forward_unit u_hazard (
    .rs_idx        (Instr_ID[25:21]),
    .rt_idx        (Instr_ID[20:16]),
    .rs_used       (1'b1),
    .rt_used       (ctrl.uses_rt),
    .id_valid      (Valid_ID),
    .flush         (Flush),
    .ex_valid      (idex_q.valid),
    .ex_reg_write  (idex_q.reg_write),
    .ex_mem_read   (idex_q.mem_read),
    .ex_dest       (idex_q.dest),
    .mem_reg_write (MemRegWrite),
    .mem_dest      (MemDest),
    .rs_sel        (rs_sel),
    .rt_sel        (rt_sel),
    .load_use      (load_use),
    .stall         (hz_stall)
  );

  // Decode the ID instruction and select forwarded operands.
  always_comb begin
    ReadReg1 = Instr_ID[25:21];
    ReadReg2 = Instr_ID[20:16];
    ctrl     = decode_ctrl(Instr_ID);
    imm_sext = DATA_W'(signed'(Instr_ID[15:0]));
    rs_val   = operand_mux(rs_sel, ReadData1, ExResult, MemResult);
    rt_val   = operand_mux(rt_sel, ReadData2, ExResult, MemResult);
  end

  // Build the next ID/EX bundle; killed, empty or stalled slots become bubbles.
  always_comb begin
    idex_d = IDEX_BUBBLE;
    if (Valid_ID && !Flush && !load_use) begin
      idex_d.rs_val    = rs_val;
      idex_d.rt_val    = rt_val;
      idex_d.imm       = imm_sext;
      idex_d.pc        = PC_ID;
      idex_d.opcode    = Instr_ID[31:26];
      idex_d.funct     = Instr_ID[5:0];
      idex_d.dest      = ctrl.dest;
      idex_d.reg_write = ctrl.reg_write;
      idex_d.mem_read  = ctrl.mem_read;
      idex_d.mem_write = ctrl.mem_write;
      idex_d.valid     = 1'b1;
    end
  end

  // ---- ID/EX register boundary ----
  always_ff @(posedge clock) begin
    if (reset) idex_q <= IDEX_BUBBLE;
    else       idex_q <= idex_d;
  end

  // Drive the registered bundle and the stall onto the ports.
  always_comb begin
    Stall       = hz_stall;
    RsVal_EX    = idex_q.rs_val;
    RtVal_EX    = idex_q.rt_val;
    Imm_EX      = idex_q.imm;
    PC_EX       = idex_q.pc;
    Opcode_EX   = idex_q.opcode;
    Funct_EX    = idex_q.funct;
    DestReg_EX  = idex_q.dest;
    RegWrite_EX = idex_q.reg_write;
    MemRead_EX  = idex_q.mem_read;
    MemWrite_EX = idex_q.mem_write;
    Valid_EX    = idex_q.valid;
  end

endmodule

// File: tb/tb_decode_operand_stage.sv
// Bench for decode_operand_stage: directed table, reset corner case, random run vs model.
module tb_decode_operand_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] Instr_ID, PC_ID;
  logic        Valid_ID, Flush;
  logic [4:0]  ReadReg1, ReadReg2;
  logic [31:0] ReadData1, ReadData2, ExResult;
  logic [4:0]  MemDest;
  logic        MemRegWrite;
  logic [31:0] MemResult;
  logic        Stall;
  logic [31:0] RsVal_EX, RtVal_EX, Imm_EX, PC_EX;
  logic [5:0]  Opcode_EX, Funct_EX;
  logic [4:0]  DestReg_EX;
  logic        RegWrite_EX, MemRead_EX, MemWrite_EX, Valid_EX;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  decode_operand_stage dut (
    .clock(clock), .reset(reset), .Instr_ID(Instr_ID), .PC_ID(PC_ID),
    .Valid_ID(Valid_ID), .Flush(Flush), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
    .ReadData1(ReadData1), .ReadData2(ReadData2), .ExResult(ExResult),
    .MemDest(MemDest), .MemRegWrite(MemRegWrite), .MemResult(MemResult),
    .Stall(Stall), .RsVal_EX(RsVal_EX), .RtVal_EX(RtVal_EX), .Imm_EX(Imm_EX),
    .PC_EX(PC_EX), .Opcode_EX(Opcode_EX), .Funct_EX(Funct_EX),
    .DestReg_EX(DestReg_EX), .RegWrite_EX(RegWrite_EX), .MemRead_EX(MemRead_EX),
    .MemWrite_EX(MemWrite_EX), .Valid_EX(Valid_EX)
  );

  // Expected contents of the EX-side outputs.
  typedef struct packed {
    logic [31:0] rs, rt, imm, pc;
    logic [5:0]  op, fn;
    logic [4:0]  dest;
    logic        rw, mr, mw, valid;
  } mdl_t;

  mdl_t m;

  typedef struct {
    logic [31:0] instr;
    logic        valid, flush;
    logic [31:0] rd1, rd2, exres;
    logic [4:0]  memdest;
    logic        memrw;
    logic [31:0] memres;
    logic        e_stall;
    logic [31:0] e_rs, e_rt;
    logic        e_valid;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Operand value a source register should receive, from the forwarding rules.
  function automatic logic [31:0] m_operand(input logic [4:0] src, input logic [31:0] rf);
    if (src == 0) return 32'd0;
    if (m.valid && m.rw && !m.mr && m.dest == src) return ExResult;
    if (MemRegWrite && MemDest == src) return MemResult;
    return rf;
  endfunction

  function automatic logic m_load_use();
    logic [5:0] op;
    logic       rt_read;
    op      = Instr_ID[31:26];
    rt_read = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04);
    if (!Valid_ID || !m.valid || !m.mr || m.dest == 0) return 1'b0;
    return (m.dest == Instr_ID[25:21]) || (rt_read && m.dest == Instr_ID[20:16]);
  endfunction

  function automatic logic m_stall();
    return m_load_use() && !Flush;
  endfunction

  function automatic mdl_t m_next();
    mdl_t n;
    n = '0;
    if (!Valid_ID || Flush || m_load_use()) return n;
    n.valid = 1'b1;
    n.rs    = m_operand(Instr_ID[25:21], ReadData1);
    n.rt    = m_operand(Instr_ID[20:16], ReadData2);
    n.imm   = 32'($signed(Instr_ID[15:0]));
    n.pc    = PC_ID;
    n.op    = Instr_ID[31:26];
    n.fn    = Instr_ID[5:0];
    case (n.op)
      6'h00: begin n.dest = Instr_ID[15:11]; n.rw = 1'b1; end
      6'h23: begin n.dest = Instr_ID[20:16]; n.rw = 1'b1; n.mr = 1'b1; end
      6'h08: begin n.dest = Instr_ID[20:16]; n.rw = 1'b1; end
      6'h2B: n.mw = 1'b1;
      default: ;
    endcase
    return n;
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, ".rs"},    RsVal_EX,    m.rs);
    chk({tag, ".rt"},    RtVal_EX,    m.rt);
    chk({tag, ".imm"},   Imm_EX,      m.imm);
    chk({tag, ".pc"},    PC_EX,       m.pc);
    chk({tag, ".op"},    32'(Opcode_EX), 32'(m.op));
    chk({tag, ".fn"},    32'(Funct_EX),  32'(m.fn));
    chk({tag, ".dest"},  32'(DestReg_EX), 32'(m.dest));
    chk({tag, ".rw"},    32'(RegWrite_EX), 32'(m.rw));
    chk({tag, ".mr"},    32'(MemRead_EX),  32'(m.mr));
    chk({tag, ".mw"},    32'(MemWrite_EX), 32'(m.mw));
    chk({tag, ".valid"}, 32'(Valid_EX),    32'(m.valid));
    chk({tag, ".stall_post"}, 32'(Stall), 32'(m_stall()));
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic step(input string tag, input logic rst_i, output logic stall_pre);
    mdl_t nxt;
    reset = rst_i;
    #1;
    chk({tag, ".readreg1"}, 32'(ReadReg1), 32'(Instr_ID[25:21]));
    chk({tag, ".readreg2"}, 32'(ReadReg2), 32'(Instr_ID[20:16]));
    chk({tag, ".stall_pre"}, 32'(Stall), 32'(m_stall()));
    stall_pre = Stall;
    nxt = rst_i ? mdl_t'('0) : m_next();
    @(posedge clock);
    m = nxt;
    #1;
    check_outputs(tag);
    @(negedge clock);
    reset = 1'b0;
  endtask

  function automatic vec_t mk(input logic [31:0] instr, input logic valid, input logic flush,
                              input logic [31:0] rd1, input logic [31:0] rd2,
                              input logic [31:0] exres, input logic [4:0] memdest,
                              input logic memrw, input logic [31:0] memres,
                              input logic e_stall, input logic [31:0] e_rs,
                              input logic [31:0] e_rt, input logic e_valid);
    vec_t v;
    v.instr = instr; v.valid = valid; v.flush = flush; v.rd1 = rd1; v.rd2 = rd2;
    v.exres = exres; v.memdest = memdest; v.memrw = memrw; v.memres = memres;
    v.e_stall = e_stall; v.e_rs = e_rs; v.e_rt = e_rt; v.e_valid = e_valid;
    return v;
  endfunction

  logic [5:0] op_pool[8];

  initial begin
    logic        sp;
    logic [31:0] ins;
    string       tag;

    // instr                         valid flush rd1        rd2        exres      mdst mrw memres     stall rs          rt          valid
    tbl[0]  = mk(32'h2001_0005, 1, 0, 32'hAAAA, 32'h1111, 32'h0,     5'd0, 0, 32'h0,     0, 32'h0,     32'h1111,   1); // addi $1,$0,5
    tbl[1]  = mk(32'h0021_1020, 1, 0, 32'hDEAD, 32'hDEAD, 32'd5,     5'd0, 0, 32'h0,     0, 32'd5,     32'd5,      1); // add $2,$1,$1 <- EX
    tbl[2]  = mk(32'h2003_0009, 1, 0, 32'h1,    32'h3333, 32'h0,     5'd0, 0, 32'h0,     0, 32'h0,     32'h3333,   1); // addi $3,$0,9
    tbl[3]  = mk(32'h0063_3020, 1, 0, 32'hBEEF, 32'hBEEF, 32'd9,     5'd3, 1, 32'd7,     0, 32'd9,     32'd9,      1); // EX beats MEM
    tbl[4]  = mk(32'h0063_3020, 1, 0, 32'hBEEF, 32'hBEEF, 32'h55,    5'd3, 1, 32'd7,     0, 32'd7,     32'd7,      1); // MEM only
    tbl[5]  = mk(32'h8C04_0000, 1, 0, 32'h10,   32'h20,   32'h0,     5'd0, 0, 32'h0,     0, 32'h0,     32'h20,     1); // lw $4,0($0)
    tbl[6]  = mk(32'h0080_2820, 1, 0, 32'h77,   32'h0,    32'h0,     5'd0, 0, 32'h0,     1, 32'h0,     32'h0,      0); // load-use
    tbl[7]  = mk(32'h0080_2820, 1, 0, 32'h77,   32'h0,    32'h0,     5'd4, 1, 32'h1234,  0, 32'h1234,  32'h0,      1); // replay, MEM
    tbl[8]  = mk(32'h8C04_0000, 1, 0, 32'h10,   32'h20,   32'h0,     5'd0, 0, 32'h0,     0, 32'h0,     32'h20,     1); // lw $4 again
    tbl[9]  = mk(32'h0080_2820, 1, 1, 32'h77,   32'h0,    32'h0,     5'd0, 0, 32'h0,     0, 32'h0,     32'h0,      0); // flush wins
    tbl[10] = mk(32'h0000_3820, 1, 0, 32'h5,    32'h5,    32'h0,     5'd0, 1, 32'hFFFF,  0, 32'h0,     32'h0,      1); // $0 source
    tbl[11] = mk(32'h0021_1020, 0, 0, 32'h5,    32'h5,    32'h0,     5'd0, 0, 32'h0,     0, 32'h0,     32'h0,      0); // empty slot

    op_pool = '{6'h00, 6'h23, 6'h23, 6'h08, 6'h2B, 6'h04, 6'h00, 6'h3F};

    reset = 1'b1; Instr_ID = '0; PC_ID = '0; Valid_ID = 1'b0; Flush = 1'b0;
    ReadData1 = '0; ReadData2 = '0; ExResult = '0; MemDest = '0;
    MemRegWrite = 1'b0; MemResult = '0;
    m = '0;
    repeat (2) @(posedge clock);
    #1;
    check_outputs("reset");
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      Instr_ID = tbl[i].instr; PC_ID = 32'h100 + 32'(i * 4);
      Valid_ID = tbl[i].valid; Flush = tbl[i].flush;
      ReadData1 = tbl[i].rd1; ReadData2 = tbl[i].rd2; ExResult = tbl[i].exres;
      MemDest = tbl[i].memdest; MemRegWrite = tbl[i].memrw; MemResult = tbl[i].memres;
      tag = $sformatf("vec%0d", i);
      step(tag, 1'b0, sp);
      chk({tag, ".tbl_stall"}, 32'(sp), 32'(tbl[i].e_stall));
      chk({tag, ".tbl_rs"}, RsVal_EX, tbl[i].e_rs);
      chk({tag, ".tbl_rt"}, RtVal_EX, tbl[i].e_rt);
      chk({tag, ".tbl_valid"}, 32'(Valid_EX), 32'(tbl[i].e_valid));
    end

    // Reset landing on a load-use stall: bubble state, stall released afterwards.
    Instr_ID = 32'h8C04_0000; Valid_ID = 1'b1; Flush = 1'b0; MemRegWrite = 1'b0;
    step("rst_lw", 1'b0, sp);
    Instr_ID = 32'h0080_2820;
    step("rst_mid", 1'b1, sp);
    chk("rst_mid.stall_before", 32'(sp), 32'd1);
    chk("rst_mid.stall_after", 32'(Stall), 32'd0);
    chk("rst_mid.valid_after", 32'(Valid_EX), 32'd0);
    step("rst_after", 1'b0, sp);
    chk("rst_after.valid", 32'(Valid_EX), 32'd1);

    // Random traffic with small register indices to provoke hazards and forwarding.
    for (int n = 0; n < 500; n++) begin
      ins = $urandom;
      ins[31:26] = op_pool[$urandom_range(0, 7)];
      ins[25:21] = 5'($urandom_range(0, 5));
      ins[20:16] = 5'($urandom_range(0, 5));
      ins[15:11] = 5'($urandom_range(0, 5));
      Instr_ID    = ins;
      PC_ID       = $urandom;
      Valid_ID    = ($urandom_range(0, 9) != 0);
      Flush       = ($urandom_range(0, 9) == 0);
      ReadData1   = $urandom;
      ReadData2   = $urandom;
      ExResult    = $urandom;
      MemDest     = 5'($urandom_range(0, 5));
      MemRegWrite = 1'($urandom);
      MemResult   = $urandom;
      step($sformatf("rnd%0d", n), ($urandom_range(0, 49) == 0), sp);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
